// File: rtl/pn_token_feeder.sv
// pn_token_feeder: buffers one PN expression, checks it for its mode, replays it to the evaluator as one burst
// Ports: host stream s_valid/s_ready/s_last/s_mode/s_operator/s_in; evaluator pn_in_valid/pn_mode/pn_operator/pn_in,
// completion pn_out_valid; status busy, err/err_code (1 overflow, 2 malformed); err_cnt only with PN_ERR_CNT_EN.
module pn_token_feeder #(
  parameter int MAX_TOK = 12,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       s_last,
  input  logic [1:0] s_mode,
  input  logic       s_operator,
  input  logic [2:0] s_in,
  output logic       pn_in_valid,
  output logic [1:0] pn_mode,
  output logic       pn_operator,
  output logic [2:0] pn_in,
  input  logic       pn_out_valid,
  output logic       busy,
  output logic       err,
  output logic [1:0] err_code
`ifdef PN_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, COLLECT, DROP, CHECK, EMIT, WAIT} state_t;
  localparam logic [CNT_W-1:0] cnt_max = CNT_W'(MAX_TOK);
  localparam logic signed [CNT_W:0] lv_zero = '0;
  localparam logic signed [CNT_W:0] lv_one = (CNT_W+1)'(1);
  localparam logic signed [CNT_W:0] lv_two = (CNT_W+1)'(2);
  state_t state;
  logic [3:0] buf_q [MAX_TOK];
  logic [CNT_W-1:0] cnt, ptr, wr_idx;
  logic [1:0] mode, pos, pos_c, pos_n, m;
  logic signed [CNT_W:0] lvl, lvl_c, lvl_n;
  logic bad, bad_c, bad_n, beat, first, legal, slot_op, seen;
  assign s_ready = state == IDLE || state == COLLECT || state == DROP;
  assign busy = state != IDLE;
  assign beat = s_valid && s_ready;
  assign first = state == IDLE;
  assign m = first ? s_mode : mode;
  assign pos_c = first ? 2'd0 : pos;
  assign bad_c = first ? 1'b0 : bad;
  assign lvl_c = first ? {{CNT_W{1'b0}}, s_mode == 2'd2} : lvl;
  assign slot_op = m[0] ? pos_c == 2'd2 : pos_c == 2'd0;
  assign wr_idx = first ? '0 : cnt;
  assign legal = !bad && (mode[1] ? (mode[0] ? lvl == lv_one : lvl == lv_zero)
                                  : (cnt == CNT_W'(3) || cnt == CNT_W'(6) || cnt == CNT_W'(9)));
  always_comb begin
    pos_n = pos_c == 2'd2 ? 2'd0 : pos_c + 2'd1;
    lvl_n = lvl_c;
    bad_n = bad_c;
    if (!m[1]) bad_n = bad_c | (s_operator != slot_op);
    else if (!m[0]) begin
      bad_n = bad_c | (lvl_c <= lv_zero);
      lvl_n = s_operator ? lvl_c + lv_one : lvl_c - lv_one;
    end else begin
      bad_n = bad_c | (s_operator && lvl_c < lv_two);
      lvl_n = s_operator ? lvl_c - lv_one : lvl_c + lv_one;
    end
    bad_n = bad_n | (lvl_n < lv_zero);
  end
  always_ff @(posedge clk)
    if (beat && state != DROP && wr_idx < cnt_max) buf_q[wr_idx] <= {s_operator, s_in};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= '0;
      mode <= '0;
      pos <= '0;
      lvl <= '0;
      bad <= 1'b0;
      seen <= 1'b0;
      pn_in_valid <= 1'b0;
      pn_mode <= '0;
      pn_operator <= 1'b0;
      pn_in <= '0;
      err <= 1'b0;
      err_code <= '0;
    end else begin
      err <= 1'b0;
      err_code <= '0;
      case (state)
        IDLE: if (beat) begin
          mode <= s_mode;
          cnt <= CNT_W'(1);
          pos <= pos_n;
          lvl <= lvl_n;
          bad <= bad_n;
          state <= s_last ? CHECK : COLLECT;
        end
        COLLECT: if (beat) begin
          if (cnt == cnt_max) begin
            err <= s_last;
            err_code <= s_last ? 2'd1 : 2'd0;
            state <= s_last ? IDLE : DROP;
          end else begin
            cnt <= cnt + CNT_W'(1);
            pos <= pos_n;
            lvl <= lvl_n;
            bad <= bad_n;
            state <= s_last ? CHECK : COLLECT;
          end
        end
        DROP: if (beat && s_last) begin
          err <= 1'b1;
          err_code <= 2'd1;
          state <= IDLE;
        end
        CHECK: begin
          if (legal) begin
            pn_in_valid <= 1'b1;
            pn_mode <= mode;
            {pn_operator, pn_in} <= buf_q[0];
            ptr <= CNT_W'(1);
            state <= EMIT;
          end else begin
            err <= 1'b1;
            err_code <= 2'd2;
            state <= IDLE;
          end
        end
        EMIT: begin
          if (ptr == cnt) begin
            pn_in_valid <= 1'b0;
            pn_mode <= '0;
            {pn_operator, pn_in} <= '0;
            seen <= 1'b0;
            state <= WAIT;
          end else begin
            {pn_operator, pn_in} <= buf_q[ptr];
            ptr <= ptr + CNT_W'(1);
          end
        end
        WAIT: begin
          if (pn_out_valid) seen <= 1'b1;
          else if (seen) begin
            seen <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef PN_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_cnt <= '0;
    else if (err && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
`endif
endmodule
